mips32_fetch_queue: RTL
=======================

Name: mips32_fetch_queue

Overview:
Instruction fetch front end for the mips32 pipeline. It owns the PC, issues word reads to instruction memory over a request/grant/response interface, and buffers returned words with their NPC in a small FIFO. It presents IR/NPC pairs to the ID stage with a valid/ready handshake. Branch redirects from EX flush the queue and discard any responses still in flight.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2); also caps outstanding requests
ADDR_W, 10, word-address width (1024-word memory, word-addressed PC)
PC_RESET, 0, PC value loaded on reset

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  word address of request
imem_gnt  input  1  request accepted this cycle (req && gnt = issue)
imem_rvalid  input  1  response valid; responses return in issue order, one per issue
imem_rdata  input  32  response instruction word
if_valid  output  1  if_ir/if_npc valid
if_ready  input  1  ID accepts (valid && ready = pop)
if_ir  output  32  instruction word (FIFO head)
if_npc  output  ADDR_W  address of instruction + 1
redirect  input  1  taken branch: flush and restart fetch
redirect_pc  input  ADDR_W  branch target
halt  input  1  HLT decoded: stop issuing new requests

Behaviour:
- Reset (async, immediate): pc=PC_RESET, FIFO empty, outstanding=0, discard=0, state=FETCH; imem_req=0, if_valid=0, if_ir=0, if_npc=0.
- FSM: FETCH issues requests; HALTED issues none. FETCH->HALTED when halt=1. HALTED->FETCH only on redirect. Reset -> FETCH.
- Issue rule: imem_req=1 iff state==FETCH, no redirect this cycle, and (fifo_count + outstanding) < DEPTH. Guarantees no FIFO overflow. imem_addr=pc. On issue: pc<=pc+1, wrapping modulo 2^ADDR_W; outstanding++.
- Each issue records its address; on imem_rvalid with discard==0, push {rdata, addr+1 mod 2^ADDR_W}; outstanding--. FIFO is registered: rvalid in cycle M gives if_valid at M+1 at the earliest.
- Pop: if_valid && if_ready advances the head. Simultaneous push and pop are allowed when full or empty-with-push (count stays consistent).
- Redirect (highest priority, cycle N): FIFO cleared; pc<=redirect_pc; discard<=outstanding after counting any issue granted in cycle N; a response arriving in cycle N is also dropped. No request in cycle N. First new request at N+1 with imem_addr=redirect_pc. if_valid=0 at N+1.
- While discard>0, each rvalid decrements discard and outstanding and pushes nothing. New requests may issue during discard; ordering keeps stale responses first.
- halt and redirect in the same cycle: redirect wins, state=FETCH.
- In HALTED, outstanding responses still land, and the FIFO drains normally to ID.
- rvalid with outstanding==0 is a protocol error: ignored (assertion in sim).
- Counter widths: $clog2(DEPTH+1) bits for fifo_count, outstanding and discard.

Optional Feature:
Macro FETCH_STATS_EN. When defined, adds outputs stat_fetched[31:0] (pushes into FIFO), stat_flushed[31:0] (entries plus discarded responses lost to redirects) and stat_stall[31:0] (cycles in FETCH with imem_req=0 and no redirect). All reset to 0 and saturate at all-ones. When undefined, these ports and their logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package mips32_pkg: opcode constants (ADD..BEQZ, HLT), instruction-type encodings, instruction field slice positions, word/address width constants.
- One sub-module, mips32_sync_fifo (parameters WIDTH, DEPTH; push/pop/flush/count/full/empty). It holds {ir, npc}. PC, issue, discard logic and the FSM stay in the top.

Test Plan:
- Zero-latency memory (gnt=1, rvalid the cycle after issue), if_ready=1, mem[0..3]=distinct words -> if_ir sequence mem[0..3], if_npc 1,2,3,4, one per cycle after a 2-cycle fill.
- if_ready=0 for 10 cycles -> exactly DEPTH=4 issues, imem_req drops, no FIFO entries lost. Ready=1 again -> words in order, no gaps or duplicates.
- 3-cycle response latency, 2 requests outstanding, redirect_pc=0x040 -> both stale responses dropped; next if_ir=mem[0x040], if_npc=0x041.
- pc=0x3FF, continuous fetch -> if_npc 0x000 for that word; next imem_addr=0x000.
- halt=1 with 2 in flight -> no further imem_req; the 2 words still reach ID. Then redirect to 0x010 -> fetch resumes at 0x010.
- rst asserted mid-burst with outstanding=2 -> all outputs 0 immediately. After release, first imem_addr=PC_RESET, and late responses are not pushed (bench must not send them).

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: opcodes, instruction classes, field positions,
// widths and the fetch front-end state type.
package mips32_pkg;

   localparam int WORD_W      = 32;
   localparam int IMEM_ADDR_W = 10;

   typedef enum logic [5:0] {
      OP_ADD   = 6'b000000,
      OP_SUB   = 6'b000001,
      OP_AND   = 6'b000010,
      OP_OR    = 6'b000011,
      OP_SLT   = 6'b000100,
      OP_MUL   = 6'b000101,
      OP_LW    = 6'b001000,
      OP_SW    = 6'b001001,
      OP_ADDI  = 6'b001010,
      OP_SUBI  = 6'b001011,
      OP_SLTI  = 6'b001100,
      OP_BNEQZ = 6'b001101,
      OP_BEQZ  = 6'b001110,
      OP_HLT   = 6'b111111
   } opcode_t;

   typedef enum logic [2:0] {
      TYPE_RR_ALU,
      TYPE_RM_ALU,
      TYPE_LOAD,
      TYPE_STORE,
      TYPE_BRANCH,
      TYPE_HALT
   } instr_type_t;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   typedef enum logic {
      FETCH,
      HALTED
   } fetch_state_t;

   function automatic instr_type_t instr_type(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return TYPE_RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     return TYPE_RM_ALU;
         OP_LW:                                         return TYPE_LOAD;
         OP_SW:                                         return TYPE_STORE;
         OP_BNEQZ, OP_BEQZ:                             return TYPE_BRANCH;
         default:                                       return TYPE_HALT;
      endcase
   endfunction

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch front-end bundle: instruction memory request/response, IF->ID
// handshake and the EX redirect/halt controls.
interface mips32_fetch_queue_if
   import mips32_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [WORD_W-1:0] imem_rdata;
   logic              if_valid;
   logic              if_ready;
   logic [WORD_W-1:0] if_ir;
   logic [ADDR_W-1:0] if_npc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;

   modport master (
      output imem_req, imem_addr, if_valid, if_ir, if_npc,
      input  imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_ir, if_npc,
      output imem_gnt, imem_rvalid, imem_rdata, if_ready, redirect, redirect_pc, halt
   );
endinterface

// File: rtl/mips32_sync_fifo.sv
// Registered synchronous FIFO with flush; a push into a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module mips32_sync_fifo #(
   parameter  int WIDTH = 42,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/mips32_fetch_queue.sv
// mips32 instruction fetch front end: PC, imem request issue, response FIFO.
// Optional FETCH_STATS_EN adds saturating fetch/flush/stall counters.
module mips32_fetch_queue
   import mips32_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input logic                  clk,
   input logic                  rst,
   mips32_fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]          stat_fetched,
   output logic [31:0]          stat_flushed,
   output logic [31:0]          stat_stall
`endif
);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int SUM_W   = CNT_W + 1;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = WORD_W + ADDR_W;

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  outstanding_nxt;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W-1:0]  fifo_count;
   logic [SUM_W-1:0]  in_flight;
   logic [ADDR_W-1:0] npc_ring [DEPTH];
   logic [PTR_W-1:0]  ring_wr;
   logic [PTR_W-1:0]  ring_rd;
   logic              issue;
   logic              resp_take;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ENTRY_W-1:0] head;

   // Buffered words plus requests in flight never exceed DEPTH, so every response has a slot.
   assign in_flight       = {1'b0, fifo_count} + {1'b0, outstanding};
   assign bus.imem_req    = !rst && (state == FETCH) && !bus.redirect && (in_flight < SUM_W'(DEPTH));
   assign bus.imem_addr   = pc;
   assign issue           = bus.imem_req && bus.imem_gnt;
   assign resp_take       = bus.imem_rvalid && (outstanding != '0);
   assign push            = resp_take && (discard == '0) && !bus.redirect;
   assign pop             = !fifo_empty && bus.if_ready && !bus.redirect;
   assign outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp_take);
   assign bus.if_valid    = !fifo_empty;
   assign bus.if_ir       = head[ENTRY_W-1 -: WORD_W];
   assign bus.if_npc      = head[ADDR_W-1:0];

   // Redirect restarts fetch and marks every response still in flight as stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= PC_RESET;
         outstanding <= '0;
         discard     <= '0;
         ring_wr     <= '0;
         ring_rd     <= '0;
      end else begin
         if (bus.redirect)  state <= FETCH;
         else if (bus.halt) state <= HALTED;

         if (bus.redirect) pc <= bus.redirect_pc;
         else if (issue)   pc <= pc + ADDR_W'(1);

         outstanding <= outstanding_nxt;

         if (bus.redirect)                    discard <= outstanding_nxt;
         else if (resp_take && discard != '0) discard <= discard - CNT_W'(1);

         if (issue)     ring_wr <= ring_wr + PTR_W'(1);
         if (resp_take) ring_rd <= ring_rd + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (issue) npc_ring[ring_wr] <= pc + ADDR_W'(1);
   end

   mips32_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .wdata ({bus.imem_rdata, npc_ring[ring_rd]}),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A response with nothing outstanding is a memory protocol error and is ignored.
   assert property (@(posedge clk) disable iff (rst) bus.imem_rvalid |-> (outstanding != '0));
   assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);

`ifdef FETCH_STATS_EN
   // Flush losses count both cleared entries and every response dropped as stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
         stat_stall   <= '0;
      end else begin
         stat_fetched <= sat_add32(stat_fetched, 32'(push));
         stat_flushed <= sat_add32(stat_flushed,
                                   (bus.redirect ? 32'(fifo_count) : 32'd0) +
                                   32'(resp_take && (discard != '0 || bus.redirect)));
         stat_stall   <= sat_add32(stat_stall,
                                   32'((state == FETCH) && !bus.imem_req && !bus.redirect));
      end
   end
`endif
endmodule
